// File: rtl/push_sw_array_if.sv
// Signal bundle between board push-buttons and the push_sw_array front end.
// The master drives the raw buttons and clears; the slave returns the debounced state, pulses and counters.
interface push_sw_array_if #(
  parameter int N_CH    = 4,
  parameter int CNT_LEN = 8
);
  logic [N_CH-1:0]         i_buttons;
  logic [N_CH-1:0]         i_clr;
  logic [N_CH-1:0]         o_level;
  logic [N_CH-1:0]         o_press;
  logic [N_CH-1:0]         o_release;
  logic [N_CH-1:0]         o_long;
  logic [N_CH*CNT_LEN-1:0] o_cnt;

  modport master (
    output i_buttons, i_clr,
    input  o_level, o_press, o_release, o_long, o_cnt
  );

  modport slave (
    input  i_buttons, i_clr,
    output o_level, o_press, o_release, o_long, o_cnt
  );
endinterface

// File: rtl/push_sw_array.sv
// Multi-channel push-button front end: 2-flop synchroniser, stable-duration debounce,
// press/release/long-press pulses and a per-channel press counter (wrap or saturate).
module push_sw_array #(
  parameter int N_CH       = 4,
  parameter int CNT_LEN    = 8,
  parameter int DB_LEN     = 16,
  parameter int LONG_LEN   = 1000,
  parameter int ACTIVE_LOW = 1,
  parameter int SAT_MODE   = 0
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  push_sw_array_if.slave  bus
);

  localparam int DB_W   = $clog2(DB_LEN);
  localparam int HOLD_W = $clog2(LONG_LEN + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_LEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_LEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_STOP = HOLD_W'(LONG_LEN);
  localparam logic              ACT_L     = (ACTIVE_LOW != 0);
  localparam logic              SAT       = (SAT_MODE != 0);

  logic [N_CH-1:0]              s1;
  logic [N_CH-1:0]              s2;
  logic [N_CH-1:0]              level;
  logic [N_CH-1:0]              press;
  logic [N_CH-1:0]              rel;
  logic [N_CH-1:0]              lng;
  logic [N_CH-1:0][DB_W-1:0]    db_cnt;
  logic [N_CH-1:0][HOLD_W-1:0]  hold;
  logic [N_CH-1:0][CNT_LEN-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s1     <= '0;
      s2     <= '0;
      level  <= '0;
      press  <= '0;
      rel    <= '0;
      lng    <= '0;
      db_cnt <= '0;
      hold   <= '0;
      cnt    <= '0;
    end else begin
      s1 <= bus.i_buttons ^ {N_CH{ACT_L}};
      s2 <= s1;
      for (int unsigned k = 0; k < N_CH; k++) begin
        press[k] <= 1'b0;
        rel[k]   <= 1'b0;
        lng[k]   <= 1'b0;

        if (s2[k] == level[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          db_cnt[k] <= '0;
          level[k]  <= ~level[k];
          press[k]  <= ~level[k];
          rel[k]    <= level[k];
        end else begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end

        // Hold counter parks at LONG_LEN after firing so o_long occurs once per press.
        if (!level[k]) begin
          hold[k] <= '0;
        end else if (hold[k] == HOLD_LAST) begin
          hold[k] <= HOLD_STOP;
          lng[k]  <= 1'b1;
        end else if (hold[k] != HOLD_STOP) begin
          hold[k] <= hold[k] + 1'b1;
        end

        // A clear coincident with a press pulse keeps that press in the count.
        if (bus.i_clr[k]) begin
          cnt[k] <= CNT_LEN'(press[k]);
        end else if (press[k] && !(SAT && (cnt[k] == '1))) begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  assign bus.o_level   = level;
  assign bus.o_press   = press;
  assign bus.o_release = rel;
  assign bus.o_long    = lng;
  assign bus.o_cnt     = cnt;

endmodule
